pipelined_addsub: RTL and testbench

- Parametrised, pipelined carry-lookahead add/subtract unit; next generation of the team's combinational 32-bit CLA adder.
- Operand width, lookahead group size and pipeline depth are configurable. Each pipeline stage resolves one slice of the word and forwards its carry to the next stage.
- Adds subtract mode, carry-in and carry/overflow/zero flags. Uses a valid/ready handshake with backpressure so it can sit directly in the ALU datapath between issue and writeback.

---
 rtl/alu_pkg.sv | 19 +
 rtl/cla_group.sv | 42 ++++
 rtl/pipelined_addsub.sv | 170 +++++++++++++++++
 tb/tb_pipelined_addsub.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encoding and slice/group sizing.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bits resolved by each pipeline stage.
    function automatic int slice_width(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

    // Lookahead groups per stage.
    function automatic int group_count(input int width, input int stages, input int block);
        return (stages > 0 && block > 0) ? width / (stages * block) : 1;
    endfunction

endpackage

// File: rtl/cla_group.sv
// BLOCK-bit carry-lookahead group: sum plus group propagate/generate for the next lookahead level.
// Latency: combinational.
// Backpressure: none; pure datapath.
module cla_group #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a_i,
    input  logic [BLOCK-1:0] b_i,
    input  logic             cin_i,
    output logic [BLOCK-1:0] sum_o,
    output logic             p_o,
    output logic             g_o
);

    logic [BLOCK-1:0] prop;
    logic [BLOCK-1:0] gen;
    logic [BLOCK-1:0] carry;

    assign prop = a_i ^ b_i;
    assign gen  = a_i & b_i;

    // Carry into each bit of the group, seeded by the group carry-in.
    always_comb begin
        carry    = '0;
        carry[0] = cin_i;
        for (int i = 1; i < BLOCK; i++) begin
            carry[i] = gen[i-1] | (prop[i-1] & carry[i-1]);
        end
    end

    // Group generate: a carry leaves the group regardless of cin_i.
    always_comb begin
        g_o = 1'b0;
        for (int i = 0; i < BLOCK; i++) begin
            g_o = gen[i] | (prop[i] & g_o);
        end
    end

    assign sum_o = prop ^ carry;
    assign p_o   = &prop;

endmodule

// File: rtl/pipelined_addsub.sv
// Skewed-pipeline CLA add/subtract; each stage resolves one WIDTH/STAGES slice and registers its carry.
// Latency: a beat accepted on edge n is presented from edge n+STAGES-1 (all outputs registered).
// Backpressure: in_ready = !out_valid || out_ready; on a stall every stage, bubbles included, holds.
module pipelined_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int  S      = slice_width(WIDTH, STAGES);
    localparam int  NG     = group_count(WIDTH, STAGES, BLOCK);
    localparam int  DIV    = (STAGES >= 1 && BLOCK >= 1) ? STAGES * BLOCK : 1;
    localparam bit  CFG_OK = (STAGES >= 1) && (BLOCK >= 1) && ((WIDTH % DIV) == 0);

    if (!CFG_OK) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES*BLOCK and STAGES >= 1");
    end

    // Result of the last stage, before the output register.
    logic             fin_vld;
    logic [WIDTH-1:0] fin_sum;
    logic             fin_carry;
    logic             fin_ovf;
    logic             fin_zero;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_carry_q;
    logic             out_ovf_q;
    logic             out_zero_q;

    assign in_ready = !out_valid_q || out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        // Operand bits still to be processed from this stage upward.
        localparam int BW = WIDTH - k*S;

        // Lower k*S bits hold finished sum slices; the rest is still operand A.
        logic [WIDTH-1:0] word;
        logic [BW-1:0]    opb;
        logic             cin;
        logic             vld;
        logic [NG-1:0]    grp_p;
        logic [NG-1:0]    grp_g;
        logic [NG:0]      grp_c;
        logic [S-1:0]     slice_sum;
        logic [WIDTH-1:0] word_d;

        if (k == 0) begin : g_head
            // SUB is a + ~b + ~borrow, so invert B and the carry-in up front.
            assign word = in_a;
            assign opb  = (in_op == OP_SUB) ? ~in_b : in_b;
            assign cin  = (in_op == OP_SUB) ? ~in_cin : in_cin;
            assign vld  = in_valid;
        end else begin : g_link
            assign word = g_stg[k-1].g_rank.word_q;
            assign opb  = g_stg[k-1].g_rank.opb_q;
            assign cin  = g_stg[k-1].g_rank.carry_q;
            assign vld  = g_stg[k-1].g_rank.vld_q;
        end

        for (genvar j = 0; j < NG; j++) begin : g_grp
            cla_group #(.BLOCK(BLOCK)) u_grp (
                .a_i   (word[k*S + j*BLOCK +: BLOCK]),
                .b_i   (opb[j*BLOCK +: BLOCK]),
                .cin_i (grp_c[j]),
                .sum_o (slice_sum[j*BLOCK +: BLOCK]),
                .p_o   (grp_p[j]),
                .g_o   (grp_g[j])
            );
        end

        // Second-level lookahead: every group carry is a flat sum of products of cin and group P/G.
        always_comb begin
            logic term;
            term     = 1'b0;
            grp_c    = '0;
            grp_c[0] = cin;
            for (int j = 0; j < NG; j++) begin
                grp_c[j+1] = cin;
                for (int i = 0; i <= j; i++) begin
                    grp_c[j+1] = grp_c[j+1] & grp_p[i];
                end
                for (int i = 0; i <= j; i++) begin
                    term = grp_g[i];
                    for (int m = i + 1; m <= j; m++) begin
                        term = term & grp_p[m];
                    end
                    grp_c[j+1] = grp_c[j+1] | term;
                end
            end
        end

        // Replace this stage's slice of A with its freshly computed sum.
        always_comb begin
            word_d             = word;
            word_d[k*S +: S]   = slice_sum;
        end

        if (k < STAGES - 1) begin : g_rank
            logic [WIDTH-1:0]  word_q;
            logic [BW-S-1:0]   opb_q;
            logic              carry_q;
            logic              vld_q;

            // Shift the beat (or bubble) one slice forward; freeze on a stall.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_q  <= '0;
                    opb_q   <= '0;
                    carry_q <= 1'b0;
                    vld_q   <= 1'b0;
                end else if (in_ready) begin
                    word_q  <= word_d;
                    opb_q   <= opb[BW-1:S];
                    carry_q <= grp_c[NG];
                    vld_q   <= vld;
                end
            end
        end else begin : g_tail
            // A's sign bit is still intact in word because the top slice lands only in word_d.
            assign fin_vld   = vld;
            assign fin_sum   = word_d;
            assign fin_carry = grp_c[NG];
            assign fin_ovf   = (word[WIDTH-1] == opb[BW-1]) && (word_d[WIDTH-1] != word[WIDTH-1]);
            assign fin_zero  = (word_d == '0);
        end
    end

    // Output register; result fields read as zero whenever no beat is present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_zero_q  <= 1'b0;
        end else if (in_ready) begin
            out_valid_q <= fin_vld;
            out_sum_q   <= fin_vld ? fin_sum : '0;
            out_carry_q <= fin_vld & fin_carry;
            out_ovf_q   <= fin_vld & fin_ovf;
            out_zero_q  <= fin_vld & fin_zero;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_carry = out_carry_q;
    assign out_ovf   = out_ovf_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed and throttled-stream bench for pipelined_addsub (WIDTH=32, BLOCK=4, STAGES=2).
// Latency: results expected on the edge after acceptance.
// Backpressure: out_ready throttled to exercise stalls, bubbles and in_ready.
module tb_pipelined_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_op;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_carry;
    logic        out_ovf;
    logic        out_zero;

    int n_cmp = 0;
    int n_bad = 0;

    pipelined_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    // Behavioural reference: {zero, ovf, carry, sum} from plain and signed arithmetic.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic op, input logic cin);
        logic signed [33:0] sa, sb, sc, sr;
        logic        [32:0] ur;
        logic               carry;
        logic               ovf;
        sa = $signed({{2{a[31]}}, a});
        sb = $signed({{2{b[31]}}, b});
        sc = $signed({33'd0, cin});
        if (op == 1'b0) begin
            ur    = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            carry = ur[32];
            sr    = sa + sb + sc;
        end else begin
            ur    = {1'b0, a} - {1'b0, b} - {32'd0, cin};
            carry = !ur[32];
            sr    = sa - sb - sc;
        end
        ovf = (sr > 34'sd2147483647) || (sr < -34'sd2147483648);
        return {(ur[31:0] == 32'd0), ovf, carry, ur[31:0]};
    endfunction

    // One isolated beat with out_ready held high and hand-computed expectations.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic cin, input logic [31:0] es,
                         input logic ec, input logic eo, input logic ez);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_a = a; in_b = b; in_op = op; in_cin = cin; in_valid = 1'b1;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678;
        check({tag, ".early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".sum"},   out_sum,         es);
        check({tag, ".carry"}, 32'(out_carry), 32'(ec));
        check({tag, ".ovf"},   32'(out_ovf),   32'(eo));
        check({tag, ".zero"},  32'(out_zero),  32'(ez));
        @(posedge clk); #1;
        check({tag, ".drain"}, 32'(out_valid), 32'd0);
    endtask

    // Stream of beats against a queue of model results; rnd selects random throttling,
    // otherwise a bubble on cycle 3 and out_ready low on cycles 6..8.
    task automatic run_traffic(input string tag, input int nbeats, input bit rnd, input int max_cyc);
        logic [34:0] expq[$];
        logic [34:0] h;
        logic [31:0] a, b;
        logic        op, cin;
        int          sent;
        int          got;
        int          cyc;
        sent = 0; got = 0; cyc = 0;
        while (got < nbeats && cyc < max_cyc) begin
            @(posedge clk); #1;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    check({tag, ".spurious"}, 32'(out_valid), 32'd0);
                end else begin
                    h = expq[0];
                    check({tag, ".sum"},   out_sum,         h[31:0]);
                    check({tag, ".carry"}, 32'(out_carry), 32'(h[32]));
                    check({tag, ".ovf"},   32'(out_ovf),   32'(h[33]));
                    check({tag, ".zero"},  32'(out_zero),  32'(h[34]));
                end
            end
            if (!rnd && cyc == 5) check({tag, ".bubble"}, 32'(out_valid), 32'd0);
            out_ready = rnd ? ($urandom_range(3) != 0) : !(cyc >= 6 && cyc <= 8);
            #1;
            if (!rnd && cyc >= 6 && cyc <= 8) check({tag, ".stall_rdy"}, 32'(in_ready), 32'd0);
            check({tag, ".in_ready"}, 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid && out_ready && expq.size() > 0) begin
                void'(expq.pop_front());
                got++;
            end
            in_valid = 1'b0;
            if (sent < nbeats && (rnd ? ($urandom_range(3) != 0) : (cyc != 3))) begin
                a = $urandom; b = $urandom;
                op = 1'($urandom_range(1)); cin = 1'($urandom_range(1));
                in_a = a; in_b = b; in_op = op; in_cin = cin; in_valid = 1'b1;
                if (in_ready) begin
                    expq.push_back(model(a, b, op, cin));
                    sent++;
                end
            end
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".beats"},    32'(got),         32'(nbeats));
        check({tag, ".leftover"}, 32'(expq.size()), 32'd0);
    endtask

    initial begin
        #6000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_cin = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst.valid",    32'(out_valid), 32'd0);
        check("rst.sum",      out_sum,         32'd0);
        check("rst.carry",    32'(out_carry), 32'd0);
        check("rst.ovf",      32'(out_ovf),   32'd0);
        check("rst.zero",     32'(out_zero),  32'd0);
        check("rst.in_ready", 32'(in_ready),  32'd1);
        #8 rst_n = 1'b1;

        do_op("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        do_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        do_op("add_xstage", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        do_op("add_cin",    32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        do_op("add_small",  32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
        do_op("sub_neg",    32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        do_op("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        do_op("sub_borrow", 32'h0000_0009, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b0);
        do_op("sub_zero",   32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        run_traffic("stream", 8, 1'b0, 200);

        // Reset with two beats in flight: outputs must clear without a clock edge.
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_a = 32'd10; in_b = 32'd20; in_op = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 32'd30; in_b = 32'd40;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rstmid.pre", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid.valid",    32'(out_valid), 32'd0);
        check("rstmid.sum",      out_sum,         32'd0);
        check("rstmid.carry",    32'(out_carry), 32'd0);
        check("rstmid.ovf",      32'(out_ovf),   32'd0);
        check("rstmid.zero",     32'(out_zero),  32'd0);
        check("rstmid.in_ready", 32'(in_ready),  32'd1);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rstmid.stale", 32'(out_valid), 32'd0);
        end
        do_op("post_rst", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);

        run_traffic("random", 10000, 1'b1, 40000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
